// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
//
// Two-port round-robin arbiter and sequencer in front of a shared 8-bit
// registered calculator (add/sub/mul/shl). One transaction is in flight at a
// time. It walks IDLE -> ISSUE -> CAPTURE -> RESPOND:
//   IDLE    : grant one pending request. On a tie the port named by ptr wins.
//   ISSUE   : pulse calc_enb for one cycle with the latched operands.
//   CAPTURE : latch the calculator's registered result.
//   RESPOND : present the result to the winning port until it is taken.
//             ptr then moves to the other port.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid[i] and ready[i] are both 1. The producer holds valid and its
// payload stable until that edge. The consumer may raise ready without waiting.
//
// Optional feature macro: CALC_ARB_STATS_EN
//   defined   : done_cnt0/done_cnt1 count response handshakes per port
//               (wrapping, cleared by reset).
//   undefined : done_cnt0/done_cnt1 are tied to 0.
//
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   req_valid  in  [1:0]  per-port request valid
//   req_ready  out [1:0]  per-port request accepted
//   req_a      in  [15:0] operand a, [7:0] port 0, [15:8] port 1
//   req_b      in  [15:0] operand b, same packing
//   req_modo   in  [3:0]  mode, [1:0] port 0, [3:2] port 1
//   rsp_valid  out [1:0]  result valid for port i
//   rsp_ready  in  [1:0]  port i takes the result
//   rsp_c      out [7:0]  result data (shared)
//   calc_enb   out        calculator enable
//   calc_a/b   out [7:0]  calculator operands
//   calc_modo  out [1:0]  calculator mode
//   calc_c     in  [7:0]  calculator registered result
//   done_cnt0/1 out [CNT_W-1:0] completion counters
//   dbg_state  out [1:0]  current FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RESPOND)
// -----------------------------------------------------------------------------
module calc_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [3:0]       req_modo,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [7:0]       rsp_c,
    output logic             calc_enb,
    output logic [7:0]       calc_a,
    output logic [7:0]       calc_b,
    output logic [1:0]       calc_modo,
    input  logic [7:0]       calc_c,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       gnt_q, gnt_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [1:0] op_modo_q, op_modo_d;
    logic [7:0] result_q, result_d;
    logic       win;

    // Winner among pending requests. The pointer only matters when both are
    // pending. With only port 1 pending the answer is simply port 1.
    always_comb begin
        win = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            op_a_q    <= 8'h00;
            op_b_q    <= 8'h00;
            op_modo_q <= 2'b00;
            result_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_modo_q <= op_modo_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_modo_d = op_modo_q;
        result_d  = result_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        calc_enb  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // req_ready is combinational. It is gated by rst so it stays
                // low while reset is held, even though IDLE is the reset state.
                if (rst && (req_valid != 2'b00)) begin
                    req_ready = win ? 2'b10 : 2'b01;
                    gnt_d     = win;
                    op_a_d    = win ? req_a[15:8]   : req_a[7:0];
                    op_b_d    = win ? req_b[15:8]   : req_b[7:0];
                    op_modo_d = win ? req_modo[3:2] : req_modo[1:0];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                calc_enb = 1'b1;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                result_d = calc_c;
                state_d  = S_RESPOND;
            end
            S_RESPOND: begin
                rsp_valid = gnt_q ? 2'b10 : 2'b01;
                if (rsp_ready[gnt_q]) begin
                    ptr_d   = ~gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign calc_a    = op_a_q;
    assign calc_b    = op_b_q;
    assign calc_modo = op_modo_q;
    assign rsp_c     = result_q;
    assign dbg_state = state_q;

`ifdef CALC_ARB_STATS_EN
    logic             rsp_hs;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    assign rsp_hs = (state_q == S_RESPOND) && rsp_ready[gnt_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (rsp_hs) begin
            if (gnt_q) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
        end
    end

    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;
`else
    assign done_cnt0 = '0;
    assign done_cnt1 = '0;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_calc_arbiter
//
// Bench for calc_arbiter. It contains a behavioural calculator that sits
// behind the DUT. It also keeps a transaction-level reference model: a queue
// of expected results, the age of the in-flight transaction and the
// round-robin pointer. That model is compared against the DUT on every falling
// edge. Directed tests pin the model with hand-computed results. A randomized
// phase follows them.
// -----------------------------------------------------------------------------
module tb_calc_arbiter;

    localparam int CNT_W = 2;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [15:0]      req_a = 16'h0;
    logic [15:0]      req_b = 16'h0;
    logic [3:0]       req_modo = 4'h0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b00;
    logic [7:0]       rsp_c;
    logic             calc_enb;
    logic [7:0]       calc_a;
    logic [7:0]       calc_b;
    logic [1:0]       calc_modo;
    logic [7:0]       calc_c;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    calc_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_modo  (req_modo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .calc_enb  (calc_enb),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_modo (calc_modo),
        .calc_c    (calc_c),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1),
        .dbg_state (dbg_state)
    );

    function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] m);
        logic [15:0] wide;
        case (m)
            2'b00:   wide = {8'h00, a} + {8'h00, b};
            2'b01:   wide = {8'h00, a} - {8'h00, b};
            2'b10:   wide = {8'h00, a} * {8'h00, b};
            default: wide = {8'h00, a} << b;
        endcase
        return wide[7:0];
    endfunction

    // Behavioural registered calculator; shares the block's reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) calc_c <= 8'h00;
        else if (calc_enb) calc_c <= calc_fn(calc_a, calc_b, calc_modo);
    end

    // ---------------- check bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] exp_q[$];
    bit         m_busy = 1'b0;
    int         m_age  = 0;
    int         m_port = 0;
    bit         m_ptr  = 1'b0;
    int         m_cnt[2] = '{0, 0};
    logic [7:0] m_a, m_b;
    logic [1:0] m_modo;
    logic [1:0] e_rr, e_rv;
    logic       e_enb;
    int         w;

    function automatic int exp_cnt(input int c);
`ifdef CALC_ARB_STATS_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_c", rsp_c, 0);
                chk("rst_calc_enb", calc_enb, 0);
                chk("rst_calc_a", calc_a, 0);
                chk("rst_calc_b", calc_b, 0);
                chk("rst_calc_modo", calc_modo, 0);
                chk("rst_done_cnt0", done_cnt0, 0);
                chk("rst_done_cnt1", done_cnt1, 0);
                m_busy = 1'b0;
                m_ptr  = 1'b0;
                m_cnt  = '{0, 0};
                exp_q.delete();
            end else begin
                e_rr = 2'b00; e_rv = 2'b00; e_enb = 1'b0; w = 0;
                if (!m_busy) begin
                    if (req_valid != 2'b00) begin
                        w = (req_valid == 2'b11) ? (m_ptr ? 1 : 0) : (req_valid[1] ? 1 : 0);
                        e_rr = (w == 1) ? 2'b10 : 2'b01;
                    end
                end else if (m_age == 1) begin
                    e_enb = 1'b1;
                end else if (m_age >= 3) begin
                    e_rv = (m_port == 1) ? 2'b10 : 2'b01;
                end
                chk("req_ready", req_ready, e_rr);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("calc_enb", calc_enb, e_enb);
                if (e_enb) begin
                    chk("calc_a", calc_a, m_a);
                    chk("calc_b", calc_b, m_b);
                    chk("calc_modo", calc_modo, m_modo);
                end
                if (e_rv != 2'b00 && exp_q.size() > 0) chk("rsp_c", rsp_c, exp_q[0]);
                chk("done_cnt0", done_cnt0, exp_cnt(m_cnt[0]));
                chk("done_cnt1", done_cnt1, exp_cnt(m_cnt[1]));

                // advance model across the coming rising edge
                if (!m_busy) begin
                    if (req_valid != 2'b00) begin
                        m_busy = 1'b1;
                        m_age  = 1;
                        m_port = w;
                        m_a    = req_a[w*8 +: 8];
                        m_b    = req_b[w*8 +: 8];
                        m_modo = req_modo[w*2 +: 2];
                        exp_q.push_back(calc_fn(m_a, m_b, m_modo));
                    end
                end else if (m_age < 3) begin
                    m_age++;
                end else if (rsp_ready[m_port]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_port == 0);
                    m_cnt[m_port] = (m_cnt[m_port] + 1) % (1 << CNT_W);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input int p, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] m, output logic [7:0] res,
                           output int lat, output int enbs);
        bit found;
        req_a[p*8 +: 8]    = a;
        req_b[p*8 +: 8]    = b;
        req_modo[p*2 +: 2] = m;
        req_valid[p]       = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin found = 1'b1; break; end
        end
        chk("accept_wait", found, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        found = 1'b0; lat = 0; enbs = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (calc_enb) enbs++;
            if (rsp_valid[p]) begin found = 1'b1; break; end
        end
        chk("response_wait", found, 1);
        res = rsp_c;
    endtask

    task automatic wait_accept(input int p);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin found = 1'b1; break; end
        end
        chk("accept_wait", found, 1);
    endtask

    task automatic wait_rsp(input int p);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin found = 1'b1; break; end
        end
        chk("response_wait", found, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] res;
    int         lat, enbs, nresp;
    logic [1:0] hs;
    int         seq[5]      = '{1, 2, 3, 0, 1};
    int         exp_port[4] = '{0, 1, 0, 1};
    int         got_port[4];
    logic [7:0] got_c[4];

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        do_reset();

        // Single add on port 0.
        rsp_ready = 2'b11;
        run_txn(0, 8'h25, 8'h13, 2'b00, res, lat, enbs);
        chk("add_result", res, 8'h38);
        chk("add_latency", lat, 3);
        chk("add_enb_pulses", enbs, 1);
        chk("add_rsp_valid", rsp_valid, 2'b01);
        @(posedge clk); #1;

        // Completion counters on port 1.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_txn(1, 8'(k), 8'h01, 2'b00, res, lat, enbs);
            chk("stats_result", res, 8'(k + 1));
            @(posedge clk); #1;
`ifdef CALC_ARB_STATS_EN
            chk("stats_cnt1", done_cnt1, seq[k]);
`else
            chk("stats_cnt1", done_cnt1, 0 * seq[k]);
`endif
            chk("stats_cnt0", done_cnt0, 0);
        end

        // Contention: both ports pending from reset.
        rst = 1'b0;
        req_a = {8'h05, 8'h10};
        req_b = {8'h07, 8'h11};
        req_modo = {2'b01, 2'b10};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        nresp = 0;
        for (int n = 0; n < 40 && nresp < 4; n++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                got_port[nresp] = rsp_valid[1] ? 1 : 0;
                got_c[nresp]    = rsp_c;
                nresp++;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("contention_count", nresp, 4);
        for (int k = 0; k < 4; k++) begin
            chk("contention_port", got_port[k], exp_port[k]);
            chk("contention_data", got_c[k], (exp_port[k] == 1) ? 8'hFE : 8'h10);
        end
        repeat (2) @(posedge clk);
        #1;

        // Response stall on shl 0x81 by 1, with port 1 waiting meanwhile.
        rsp_ready = 2'b00;
        req_a[7:0] = 8'h81; req_b[7:0] = 8'h01; req_modo[1:0] = 2'b11;
        req_valid = 2'b01;
        wait_accept(0);
        @(posedge clk); #1;
        req_a[15:8] = 8'h03; req_b[15:8] = 8'h04; req_modo[3:2] = 2'b00;
        req_valid = 2'b10;
        enbs = 0;
        wait_rsp(0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 2'b01);
            chk("stall_rsp_c", rsp_c, 8'h02);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_calc_enb", calc_enb, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_accept(1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(1);
        chk("after_stall_data", rsp_c, 8'h07);
        @(posedge clk); #1;

        // Reset while the transaction is in CAPTURE.
        req_a[7:0] = 8'h01; req_b[7:0] = 8'h02; req_modo[1:0] = 2'b00;
        req_valid = 2'b01;
        wait_accept(0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_c", rsp_c, 0);
        chk("midrst_calc_enb", calc_enb, 0);
        chk("midrst_calc_a", calc_a, 0);
        chk("midrst_calc_b", calc_b, 0);
        chk("midrst_calc_modo", calc_modo, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        run_txn(1, 8'h09, 8'h03, 2'b01, res, lat, enbs);
        chk("midrst_port1_data", res, 8'h06);
        chk("midrst_port1_valid", rsp_valid, 2'b10);
        chk("midrst_port1_latency", lat, 3);
        @(posedge clk); #1;

        // Randomized traffic with random response back-pressure.
        for (int cyc = 0; cyc < 440; cyc++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) req_valid[p] = 1'b0;
                if (!req_valid[p] && cyc < 400 && $urandom_range(0, 2) == 0) begin
                    req_a[p*8 +: 8]    = 8'($urandom_range(0, 255));
                    req_b[p*8 +: 8]    = 8'($urandom_range(0, 255));
                    req_modo[p*2 +: 2] = 2'($urandom_range(0, 3));
                    req_valid[p]       = 1'b1;
                end
            end
            rsp_ready = (cyc < 400) ? 2'($urandom_range(0, 3)) : 2'b11;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
